// File: rtl/atualizador_atributos_if.sv
// Purpose: bundles the attribute updater's control inputs and attribute/status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; estado/novo_jogo are sampled levels, outputs are plain registers.
interface atualizador_atributos_if;
  logic [3:0] estado;
  logic       novo_jogo;
  logic [7:0] fome;
  logic [7:0] sono;
  logic [7:0] felicidade;
  logic       atualizou;
  logic       zerado;

  // State controller side: drives estado/novo_jogo, consumes the attributes.
  modport master (
    output estado,
    output novo_jogo,
    input  fome,
    input  sono,
    input  felicidade,
    input  atualizou,
    input  zerado
  );

  // Updater side.
  modport slave (
    input  estado,
    input  novo_jogo,
    output fome,
    output sono,
    output felicidade,
    output atualizou,
    output zerado
  );
endinterface

// File: rtl/atualizador_atributos.sv
// Purpose: per-tick update of fome/sono/felicidade through one shared saturating add/sub unit.
// Latency: tick edge E0 -> fome E0+1, sono E0+2, felicidade E0+3, atualizou E0+3..E0+4, zerado E0+4.
// Backpressure: none; novo_jogo aborts any sequence. Define ATUALIZADOR_CONGELA_EN to freeze updates while zerado.
module atualizador_atributos #(
  parameter int TICK_DIV  = 1000000,
  parameter int STEP_UP   = 8,
  parameter int STEP_DOWN = 1,
  parameter int INIT_VAL  = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  atualizador_atributos_if.slave bus
);

  localparam int            CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [7:0]    LP_INIT    = 8'(INIT_VAL);
  localparam logic [8:0]    LP_UP      = 9'(STEP_UP);
  localparam logic [7:0]    LP_DOWN    = 8'(STEP_DOWN);

  localparam logic [3:0] EST_IDLE     = 4'b0000;
  localparam logic [3:0] EST_DORMINDO = 4'b0001;
  localparam logic [3:0] EST_COMENDO  = 4'b0010;
  localparam logic [3:0] EST_AULA     = 4'b0100;
  localparam logic [3:0] EST_MORTO    = 4'b1000;

  typedef enum logic [2:0] {
    S_WAIT,
    S_FOME,
    S_SONO,
    S_FELIC,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_UP,
    OP_DOWN
  } op_t;

  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [3:0]    r_estado_lat;
  logic [7:0]    r_fome;
  logic [7:0]    r_sono;
  logic [7:0]    r_felic;
  logic          r_atualizou;
  logic          r_zerado;

  logic          w_tick;
  logic          w_go;
  logic          w_any_zero;
  op_t           w_op_fome;
  op_t           w_op_sono;
  op_t           w_op_felic;
  op_t           w_op;
  logic [7:0]    w_operand;
  logic [8:0]    w_sum;
  logic [7:0]    w_result;

  assign w_tick     = (r_cnt == LP_CNT_MAX);
  assign w_any_zero = (r_fome == 8'h00) | (r_sono == 8'h00) | (r_felic == 8'h00);

`ifdef ATUALIZADOR_CONGELA_EN
  // A dead pet stays frozen: no new sequence starts while zerado is set.
  assign w_go = w_tick & ~r_zerado;
`else
  assign w_go = w_tick;
`endif

  // Free-running prescaler; restarts on novo_jogo so the next tick is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.novo_jogo || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Per-attribute operation for the latched estado; anything not one-hot-legal behaves as IDLE.
  always_comb begin
    w_op_fome  = OP_DOWN;
    w_op_sono  = OP_DOWN;
    w_op_felic = OP_DOWN;
    case (r_estado_lat)
      EST_COMENDO: begin
        w_op_fome  = OP_UP;
      end
      EST_DORMINDO: begin
        w_op_sono  = OP_UP;
        w_op_felic = OP_NONE;
      end
      EST_AULA: begin
        w_op_felic = OP_UP;
      end
      EST_MORTO: begin
        w_op_fome  = OP_NONE;
        w_op_sono  = OP_NONE;
        w_op_felic = OP_NONE;
      end
      default: begin
        w_op_fome  = OP_DOWN;
      end
    endcase
  end

  // Route the attribute owned by the current state into the shared unit.
  always_comb begin
    w_operand = r_fome;
    w_op      = OP_NONE;
    case (r_state)
      S_FOME: begin
        w_operand = r_fome;
        w_op      = w_op_fome;
      end
      S_SONO: begin
        w_operand = r_sono;
        w_op      = w_op_sono;
      end
      S_FELIC: begin
        w_operand = r_felic;
        w_op      = w_op_felic;
      end
      default: begin
        w_operand = r_fome;
        w_op      = OP_NONE;
      end
    endcase
  end

  // Shared saturating unit: 9-bit add clamped at 255, subtract floored at 0.
  always_comb begin
    w_sum    = {1'b0, w_operand} + LP_UP;
    w_result = w_operand;
    case (w_op)
      OP_UP:   w_result = w_sum[8] ? 8'hFF : w_sum[7:0];
      OP_DOWN: w_result = (w_operand < LP_DOWN) ? 8'h00 : (w_operand - LP_DOWN);
      default: w_result = w_operand;
    endcase
  end

  // Sequencer: latch estado on tick, write one attribute per cycle, pulse atualizou, update zerado.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT;
      r_estado_lat <= EST_IDLE;
      r_fome       <= LP_INIT;
      r_sono       <= LP_INIT;
      r_felic      <= LP_INIT;
      r_atualizou  <= 1'b0;
      r_zerado     <= 1'b0;
    end else if (bus.novo_jogo) begin
      r_state      <= S_WAIT;
      r_estado_lat <= EST_IDLE;
      r_fome       <= LP_INIT;
      r_sono       <= LP_INIT;
      r_felic      <= LP_INIT;
      r_atualizou  <= 1'b0;
      r_zerado     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_go) begin
            r_estado_lat <= bus.estado;
            r_state      <= S_FOME;
          end
        end
        S_FOME: begin
          r_fome  <= w_result;
          r_state <= S_SONO;
        end
        S_SONO: begin
          r_sono  <= w_result;
          r_state <= S_FELIC;
        end
        S_FELIC: begin
          r_felic     <= w_result;
          r_atualizou <= 1'b1;
          r_state     <= S_CHECK;
        end
        S_CHECK: begin
          r_atualizou <= 1'b0;
          if (w_any_zero) begin
            r_zerado <= 1'b1;
          end
          r_state <= S_WAIT;
        end
        default: begin
          r_atualizou <= 1'b0;
          r_state     <= S_WAIT;
        end
      endcase
    end
  end

  assign bus.fome       = r_fome;
  assign bus.sono       = r_sono;
  assign bus.felicidade = r_felic;
  assign bus.atualizou  = r_atualizou;
  assign bus.zerado     = r_zerado;

endmodule

// File: tb/tb_atualizador_atributos.sv
// Purpose: checks three updater instances (INIT_VAL 128/250/2, TICK_DIV 16) against a schedule-based model.
// Latency: model applies spec edge offsets E0+1..E0+4 from each accepted tick.
// Backpressure: none; inputs are driven on the falling edge, outputs compared on the falling edge.
module tb_atualizador_atributos;

  localparam int TD = 16;
  localparam int SU = 8;
  localparam int SD = 1;
`ifdef ATUALIZADOR_CONGELA_EN
  localparam bit CONGELA = 1'b1;
`else
  localparam bit CONGELA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] est [3];
  logic       nj  [3];
  logic [7:0] df  [3];
  logic [7:0] ds  [3];
  logic [7:0] dl  [3];
  logic       da  [3];
  logic       dz  [3];

  int errs   = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  atualizador_atributos_if if0 ();
  atualizador_atributos_if if1 ();
  atualizador_atributos_if if2 ();

  assign if0.estado = est[0];
  assign if1.estado = est[1];
  assign if2.estado = est[2];
  assign if0.novo_jogo = nj[0];
  assign if1.novo_jogo = nj[1];
  assign if2.novo_jogo = nj[2];

  assign df[0] = if0.fome;  assign ds[0] = if0.sono;  assign dl[0] = if0.felicidade;
  assign df[1] = if1.fome;  assign ds[1] = if1.sono;  assign dl[1] = if1.felicidade;
  assign df[2] = if2.fome;  assign ds[2] = if2.sono;  assign dl[2] = if2.felicidade;
  assign da[0] = if0.atualizou;  assign dz[0] = if0.zerado;
  assign da[1] = if1.atualizou;  assign dz[1] = if1.zerado;
  assign da[2] = if2.atualizou;  assign dz[2] = if2.zerado;

  atualizador_atributos #(.TICK_DIV(TD), .STEP_UP(SU), .STEP_DOWN(SD), .INIT_VAL(128))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  atualizador_atributos #(.TICK_DIV(TD), .STEP_UP(SU), .STEP_DOWN(SD), .INIT_VAL(250))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  atualizador_atributos #(.TICK_DIV(TD), .STEP_UP(SU), .STEP_DOWN(SD), .INIT_VAL(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // ---------------- reference model ----------------
  int m_attr [3][3];
  int m_nv   [3][3];
  bit m_nz   [3];
  bit m_atu  [3];
  bit m_zer  [3];
  int m_presc[3];
  int m_tgt  [3];
  int cyc = 0;

  function automatic int init_of(int i);
    if (i == 0) return 128;
    if (i == 1) return 250;
    return 2;
  endfunction

  // Signed delta for attribute k (0 fome, 1 sono, 2 felicidade) under estado e.
  function automatic int delta(logic [3:0] e, int k);
    case (e)
      4'b0010: return (k == 0) ? SU : -SD;
      4'b0001: return (k == 0) ? -SD : ((k == 1) ? SU : 0);
      4'b0100: return (k == 2) ? SU : -SD;
      4'b1000: return 0;
      default: return -SD;
    endcase
  endfunction

  function automatic int sat(int v);
    if (v > 255) return 255;
    if (v < 0) return 0;
    return v;
  endfunction

  task automatic m_restart(int i);
    for (int k = 0; k < 3; k++) m_attr[i][k] = init_of(i);
    m_atu[i]   = 1'b0;
    m_zer[i]   = 1'b0;
    m_presc[i] = 0;
    m_tgt[i]   = -100;
  endtask

  // Model: each accepted tick at edge E0 schedules fome/sono/felicidade/zerado at E0+1..E0+4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 3; i++) m_restart(i);
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (nj[i]) begin
          m_restart(i);
        end else begin
          if (cyc == m_tgt[i] + 1) m_attr[i][0] = m_nv[i][0];
          if (cyc == m_tgt[i] + 2) m_attr[i][1] = m_nv[i][1];
          if (cyc == m_tgt[i] + 3) begin
            m_attr[i][2] = m_nv[i][2];
            m_atu[i] = 1'b1;
          end
          if (cyc == m_tgt[i] + 4) begin
            m_atu[i] = 1'b0;
            if (m_nz[i]) m_zer[i] = 1'b1;
          end
          if (m_presc[i] == TD - 1 && !(CONGELA && m_zer[i])) begin
            m_tgt[i] = cyc;
            m_nz[i]  = 1'b0;
            for (int k = 0; k < 3; k++) begin
              m_nv[i][k] = sat(m_attr[i][k] + delta(est[i], k));
              if (m_nv[i][k] == 0) m_nz[i] = 1'b1;
            end
          end
          m_presc[i] = (m_presc[i] + 1) % TD;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks = checks + 1;
    if (act != exp) begin
      errs = errs + 1;
      if (errs <= 40) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.fome", i),       int'(df[i]), m_attr[i][0]);
        chk($sformatf("u%0d.sono", i),       int'(ds[i]), m_attr[i][1]);
        chk($sformatf("u%0d.felicidade", i), int'(dl[i]), m_attr[i][2]);
        chk($sformatf("u%0d.atualizou", i),  int'(da[i]), int'(m_atu[i]));
        chk($sformatf("u%0d.zerado", i),     int'(dz[i]), int'(m_zer[i]));
      end
    end
  end

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    for (int i = 0; i < 3; i++) begin
      est[i] = 4'b0000;
      nj[i]  = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.fome0", int'(df[0]), 128);
    chk("rst.felic0", int'(dl[0]), 128);
    chk("rst.atualizou0", int'(da[0]), 0);
    chk("rst.zerado0", int'(dz[0]), 0);
    chk("rst.fome1", int'(df[1]), 250);
    chk("rst.sono2", int'(ds[2]), 2);
    cmp_en = 1'b1;
    est[1] = 4'b0010;
    rst_n  = 1'b1;

    // First tick at edge 16.
    goto(18); chk("t1.atu_before", int'(da[0]), 0);
    goto(19); chk("t1.atu_high", int'(da[0]), 1);
    chk("t1.felic0", int'(dl[0]), 127);
    goto(20); chk("t1.atu_after", int'(da[0]), 0);
    chk("t1.fome0", int'(df[0]), 127);
    chk("t1.sono0", int'(ds[0]), 127);
    chk("sat.fome1", int'(df[1]), 255);
    chk("sat.sono1", int'(ds[1]), 249);
    chk("sat.felic1", int'(dl[1]), 249);
    chk("lo.fome2", int'(df[2]), 1);

    // Restart inst0, then latch check on its next tick (edge 37).
    nj[0] = 1'b1;
    goto(21); nj[0] = 1'b0;
    chk("nj.fome0", int'(df[0]), 128);
    est[0] = 4'b0001;
    goto(35);
    chk("lo.felic2", int'(dl[2]), 0);
    chk("lo.zer_early", int'(dz[2]), 0);
    goto(36); chk("lo.zerado2", int'(dz[2]), 1);
    goto(37); est[0] = 4'b0010;
    goto(41);
    chk("latch.fome0", int'(df[0]), 127);
    chk("latch.sono0", int'(ds[0]), 136);
    chk("latch.felic0", int'(dl[0]), 128);
    est[0] = 4'b0000;

    // Third tick of inst2 (edge 48): values pinned at 0, atualizou depends on freeze build.
    goto(51);
    chk("lo.t3_atu", int'(da[2]), CONGELA ? 0 : 1);
    chk("lo.t3_fome", int'(df[2]), 0);

    // novo_jogo during S_SONO of the tick at edge 53.
    goto(54); chk("ab.fome_upd", int'(df[0]), 126);
    nj[0] = 1'b1;
    goto(55); nj[0] = 1'b0;
    chk("ab.fome0", int'(df[0]), 128);
    chk("ab.sono0", int'(ds[0]), 128);
    chk("ab.zer0", int'(dz[0]), 0);
    goto(56); chk("ab.no_atu", int'(da[0]), 0);
    goto(73); chk("ab.atu_early", int'(da[0]), 0);
    goto(74); chk("ab.atu_next", int'(da[0]), 1);
    est[0] = 4'b0011;
    goto(91);
    chk("ill.fome0", int'(df[0]), 126);
    chk("ill.sono0", int'(ds[0]), 126);
    chk("ill.felic0", int'(dl[0]), 126);

    // Random phase.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 6))
            0: est[i] = 4'b0000;
            1: est[i] = 4'b0001;
            2: est[i] = 4'b0010;
            3: est[i] = 4'b0100;
            4: est[i] = 4'b1000;
            default: est[i] = 4'($urandom_range(0, 15));
          endcase
        end
        nj[i] = ($urandom_range(0, 119) == 0);
      end
    end

    // Asynchronous reset in the middle of an inst0 sequence.
    @(negedge clk);
    for (int i = 0; i < 3; i++) nj[i] = 1'b0;
    nj[0] = 1'b1;
    est[0] = 4'b0000;
    @(negedge clk);
    nj[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (cyc == m_tgt[0] + 2) found = 1'b1;
    end
    chk("arst.mid_seq_found", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.fome0", int'(df[0]), 128);
    chk("arst.felic0", int'(dl[0]), 128);
    chk("arst.atu0", int'(da[0]), 0);
    chk("arst.zer0", int'(dz[0]), 0);
    chk("arst.sono2", int'(ds[2]), 2);
    chk("arst.zer2", int'(dz[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
